vga_tile_wr_arb: RTL and testbench
==================================

Name: vga_tile_wr_arb

Overview:
- Write-side controller for the 256-entry x 8-bit tile pixel buffer (16x16 tile, RGB332). The VGA scan-out path reads this buffer.
- Shares the single buffer write port between two requesters:
  - a host single-pixel writer;
  - an internal rectangle-fill engine that sequences one write per cycle over a sub-rectangle.
- Host writes have priority, with an anti-starvation limit so an active fill always progresses.

Parameters:
- TILE_W_BITS, 4, log2 of tile width/height (16x16).
- DATA_W, 8, pixel width (RGB332: R[7:5] G[4:2] B[1:0]).
- MAX_HOST_BURST, 4, max consecutive host grants while a fill is pending; 1..15.

Ports:
- VGA_CLK  in  1  pixel clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-high reset.
- host_wr_req  in  1  host requests one pixel write; held until acked.
- host_wr_addr  in  8  {y[3:0],x[3:0]} target address.
- host_wr_data  in  8  pixel colour.
- host_wr_ack  out  1  combinational grant; write is issued next cycle.
- fill_start  in  1  single-cycle fill command strobe.
- fill_x0, fill_y0, fill_x1, fill_y1  in  4 each  inclusive rectangle corners.
- fill_color  in  8  fill colour.
- fill_busy  out  1  fill engine not in IDLE.
- fill_done  out  1  one-cycle pulse after the last fill write is issued.
- fill_err  out  1  one-cycle pulse on a rejected command.
- mem_wr_en  out  1  registered buffer write enable.
- mem_wr_addr  out  8  registered write address = 16*y + x.
- mem_wr_data  out  8  registered write data.

Behaviour:
- Reset (RST_N=1, async):
  - FSM=IDLE.
  - mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0.
  - fill_busy=0, fill_done=0, fill_err=0, host burst counter=0.
  - host_wr_ack is forced to 0 while reset is asserted.
  - Reset mid-fill abandons the fill. There is no done pulse and no further writes.
- FSM states: IDLE, FILL, DONE.
  - IDLE + fill_start with x0<=x1 and y0<=y1: latch rect and colour, cx=x0, cy=y0, go to FILL. fill_busy=1 from the next cycle.
  - IDLE + fill_start with x0>x1 or y0>y1: fill_err=1 next cycle, stay in IDLE.
  - fill_start in FILL or DONE: ignored. No error and no effect on the latched command.
  - FILL, fill slot granted:
    - Issue a write at {cy,cx}.
    - If cx==x1: set cx=x0. If additionally cy==y1, go to DONE; otherwise cy=cy+1.
    - Otherwise cx=cx+1.
  - DONE: fill_done=1 for one cycle, then return to IDLE. fill_busy is 1 in DONE and 0 in IDLE.
- Arbitration (evaluated each cycle):
  - host_wr_ack = host_wr_req AND NOT(FSM==FILL AND burst==MAX_HOST_BURST).
  - Fill slot granted = FSM==FILL AND NOT host_wr_ack.
  - burst increments on each host grant while FSM==FILL. It resets to 0 on any fill slot grant and whenever FSM!=FILL.
  - Outside FILL, host is always granted the same cycle it requests.
- Latency:
  - Winner of cycle N appears on mem_wr_* in cycle N+1.
  - mem_wr_en=0 in any cycle after a cycle with no grant; mem_wr_addr and mem_wr_data hold their last values.
  - First fill write appears 2 cycles after fill_start: accept, then slot, then output.
- Fill of a WxH rect with no host traffic: W*H consecutive mem_wr_en cycles in row-major order, then fill_done.
- Host address/data are passed through unchecked. Any 8-bit address is legal.
- Host and fill writing the same address in adjacent cycles: later write wins in the buffer. No hazard logic is required.

Decomposition:
- Shared package vga_tile_pkg:
  - TILE_W_BITS, DATA_W.
  - FSM state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2).
  - RGB332 colour constants (RED=8'hE0, GREEN=8'h1C, BLUE=8'h03, YELLOW=8'hFC).
  - address-pack function {y,x}.
- One natural sub-module: vga_tile_rect_walker, containing the cx/cy counters, rectangle latch and last-pixel detect. The top module holds the FSM, arbiter, burst counter and output registers.

Test Plan:
- Reset mid-fill: start fill (0,0)-(15,15) colour 8'hE0, assert RST_N at write 100 -> all outputs 0 next edge; after release, no writes and no fill_done.
- Full fill, no host traffic: start (0,0)-(15,15) colour 8'hE0 -> 256 consecutive mem_wr_en cycles, addresses 0..255, data E0, fill_done pulse exactly once; buffer model all E0.
- Sub-rect fill: (2,3)-(4,4) colour 8'h1C -> 6 writes, addresses 0x32,0x33,0x34,0x42,0x43,0x44, then fill_done one cycle later.
- Rejected command: fill_start with x0=5, x1=4 -> fill_err pulse, fill_busy stays 0, no writes.
- Host priority and starvation guard: continuous host_wr_req during fill (1,1)-(1,1) with MAX_HOST_BURST=4 -> 4 host acks, then one fill write at 0x11, then host acks resume.
- Idle host write, plus a second fill_start while busy: host addr 8'hA5 data 8'h03 in IDLE -> ack same cycle; next cycle mem_wr_en=1, addr A5, data 03. fill_start while busy -> ignored; original fill completes unchanged.

Source files
------------

// File: rtl/vga_tile_pkg.sv
// Shared types and constants for the tile pixel buffer write path.
// RGB332 pixels, 16x16 tile, address packed as {y,x}.
package vga_tile_pkg;

    localparam int TILE_W_BITS = 4;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 2 * TILE_W_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam logic [DATA_W-1:0] RED    = 8'hE0;
    localparam logic [DATA_W-1:0] GREEN  = 8'h1C;
    localparam logic [DATA_W-1:0] BLUE   = 8'h03;
    localparam logic [DATA_W-1:0] YELLOW = 8'hFC;

    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [TILE_W_BITS-1:0] y,
        input logic [TILE_W_BITS-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_tile_rect_walker.sv
// Row-major walker over a latched inclusive rectangle.
// Advances one pixel per step and flags the final pixel.
module vga_tile_rect_walker
    import vga_tile_pkg::*;
(
    input  logic                   VGA_CLK,
    input  logic                   RST_N,
    input  logic                   load,
    input  logic [TILE_W_BITS-1:0] x0,
    input  logic [TILE_W_BITS-1:0] y0,
    input  logic [TILE_W_BITS-1:0] x1,
    input  logic [TILE_W_BITS-1:0] y1,
    input  logic                   step,
    output logic [ADDR_W-1:0]      addr,
    output logic                   last_pix
);

    logic [TILE_W_BITS-1:0] cx;
    logic [TILE_W_BITS-1:0] cy;
    logic [TILE_W_BITS-1:0] lx0;
    logic [TILE_W_BITS-1:0] lx1;
    logic [TILE_W_BITS-1:0] ly1;
    logic                   last_col;

    assign last_col = (cx == lx1);
    assign last_pix = last_col && (cy == ly1);
    assign addr     = pack_addr(cy, cx);

    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            cx  <= '0;
            cy  <= '0;
            lx0 <= '0;
            lx1 <= '0;
            ly1 <= '0;
        end else if (load) begin
            lx0 <= x0;
            lx1 <= x1;
            ly1 <= y1;
            cx  <= x0;
            cy  <= y0;
        end else if (step) begin
            // Wrap to the left edge; the row only moves while rows remain.
            if (last_col) begin
                cx <= lx0;
                if (cy != ly1) begin
                    cy <= cy + TILE_W_BITS'(1);
                end
            end else begin
                cx <= cx + TILE_W_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/vga_tile_wr_arb.sv
// Tile buffer write-port arbiter: host pixel writes versus rectangle fill,
// host first with a bounded burst so an active fill keeps moving.
module vga_tile_wr_arb
    import vga_tile_pkg::*;
#(
    parameter int MAX_HOST_BURST = 4
) (
    input  logic                   VGA_CLK,
    input  logic                   RST_N,
    input  logic                   host_wr_req,
    input  logic [ADDR_W-1:0]      host_wr_addr,
    input  logic [DATA_W-1:0]      host_wr_data,
    output logic                   host_wr_ack,
    input  logic                   fill_start,
    input  logic [TILE_W_BITS-1:0] fill_x0,
    input  logic [TILE_W_BITS-1:0] fill_y0,
    input  logic [TILE_W_BITS-1:0] fill_x1,
    input  logic [TILE_W_BITS-1:0] fill_y1,
    input  logic [DATA_W-1:0]      fill_color,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic                   fill_err,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [DATA_W-1:0]      mem_wr_data
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_HOST_BURST);

    fill_state_t       state;
    fill_state_t       state_nx;
    logic [3:0]        burst;
    logic [3:0]        burst_nx;
    logic [DATA_W-1:0] color;
    logic              cmd_ok;
    logic              accept;
    logic              reject;
    logic              fill_slot;
    logic              last_pix;
    logic [ADDR_W-1:0] fill_addr;

    assign cmd_ok    = (fill_x0 <= fill_x1) && (fill_y0 <= fill_y1);
    assign fill_busy = (state != IDLE);
    assign fill_done = (state == DONE);

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        reject      = 1'b0;
        burst_nx    = burst;
        host_wr_ack = host_wr_req && !RST_N
                   && !((state == FILL) && (burst == BURST_MAX));
        fill_slot   = (state == FILL) && !host_wr_ack;

        unique case (state)
            IDLE: begin
                if (fill_start) begin
                    if (cmd_ok) begin
                        accept   = 1'b1;
                        state_nx = FILL;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FILL: begin
                if (fill_slot && last_pix) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // The streak only counts host wins that held off a pending fill.
        if ((state != FILL) || fill_slot) begin
            burst_nx = '0;
        end else if (host_wr_ack) begin
            burst_nx = burst + 4'd1;
        end
    end

    vga_tile_rect_walker u_walker (
        .VGA_CLK  (VGA_CLK),
        .RST_N    (RST_N),
        .load     (accept),
        .x0       (fill_x0),
        .y0       (fill_y0),
        .x1       (fill_x1),
        .y1       (fill_y1),
        .step     (fill_slot),
        .addr     (fill_addr),
        .last_pix (last_pix)
    );

    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            state       <= IDLE;
            burst       <= '0;
            color       <= '0;
            fill_err    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            state     <= state_nx;
            burst     <= burst_nx;
            fill_err  <= reject;
            mem_wr_en <= host_wr_ack || fill_slot;
            if (accept) begin
                color <= fill_color;
            end
            if (host_wr_ack) begin
                mem_wr_addr <= host_wr_addr;
                mem_wr_data <= host_wr_data;
            end else if (fill_slot) begin
                mem_wr_addr <= fill_addr;
                mem_wr_data <= color;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_wr_arb.sv
// Self-checking bench for vga_tile_wr_arb: directed scenarios plus random
// host traffic against a queue-based model of fills and arbitration.
module tb_vga_tile_wr_arb;

    localparam int MAXB = 4;

    logic       VGA_CLK;
    logic       RST_N;
    logic       host_wr_req;
    logic [7:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic       host_wr_ack;
    logic       fill_start;
    logic [3:0] fill_x0;
    logic [3:0] fill_y0;
    logic [3:0] fill_x1;
    logic [3:0] fill_y1;
    logic [7:0] fill_color;
    logic       fill_busy;
    logic       fill_done;
    logic       fill_err;
    logic       mem_wr_en;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;

    vga_tile_wr_arb #(.MAX_HOST_BURST(MAXB)) dut (
        .VGA_CLK      (VGA_CLK),
        .RST_N        (RST_N),
        .host_wr_req  (host_wr_req),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_ack  (host_wr_ack),
        .fill_start   (fill_start),
        .fill_x0      (fill_x0),
        .fill_y0      (fill_y0),
        .fill_x1      (fill_x1),
        .fill_y1      (fill_y1),
        .fill_color   (fill_color),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .fill_err     (fill_err),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // model: phase 0 idle, 1 filling, 2 done
    int         ph;
    int         streak;
    logic [7:0] pend[$];
    logic [7:0] fcol;
    logic       e_en;
    logic       e_err;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    logic       last_ack;
    logic [7:0] mref[256];

    // observations
    logic [7:0] obs_a[$];
    logic [7:0] obs_d[$];
    int         obs_t[$];
    int         done_cnt;
    int         done_t;
    logic [7:0] mem_obs[256];

    task automatic model_reset();
        ph = 0;
        streak = 0;
        pend.delete();
        e_en = 0;
        e_err = 0;
        e_addr = 0;
        e_data = 0;
        last_ack = 0;
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        obs_t.delete();
        done_cnt = 0;
        done_t = -1;
    endtask

    task automatic step();
        logic m_ack;
        logic m_slot;
        logic ok;
        @(negedge VGA_CLK);
        m_ack  = host_wr_req && !(ph == 1 && streak == MAXB);
        m_slot = (ph == 1) && !m_ack;
        nchk += 7;
        if (host_wr_ack !== m_ack) begin
            nerr++;
            $display("FAIL ack cyc=%0d got=%b want=%b", cyc, host_wr_ack, m_ack);
        end
        if (mem_wr_en !== e_en) begin
            nerr++;
            $display("FAIL wr_en cyc=%0d got=%b want=%b", cyc, mem_wr_en, e_en);
        end
        if (mem_wr_addr !== e_addr) begin
            nerr++;
            $display("FAIL wr_addr cyc=%0d got=%h want=%h", cyc, mem_wr_addr, e_addr);
        end
        if (mem_wr_data !== e_data) begin
            nerr++;
            $display("FAIL wr_data cyc=%0d got=%h want=%h", cyc, mem_wr_data, e_data);
        end
        if (fill_busy !== (ph != 0)) begin
            nerr++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, fill_busy, ph != 0);
        end
        if (fill_done !== (ph == 2)) begin
            nerr++;
            $display("FAIL done cyc=%0d got=%b want=%b", cyc, fill_done, ph == 2);
        end
        if (fill_err !== e_err) begin
            nerr++;
            $display("FAIL err cyc=%0d got=%b want=%b", cyc, fill_err, e_err);
        end
        if (mem_wr_en === 1'b1) begin
            obs_a.push_back(mem_wr_addr);
            obs_d.push_back(mem_wr_data);
            obs_t.push_back(cyc);
            mem_obs[mem_wr_addr] = mem_wr_data;
        end
        if (fill_done === 1'b1) begin
            done_cnt++;
            done_t = cyc;
        end
        ok = (fill_x0 <= fill_x1) && (fill_y0 <= fill_y1);
        e_en = m_ack || m_slot;
        if (m_ack) begin
            e_addr = host_wr_addr;
            e_data = host_wr_data;
        end else if (m_slot) begin
            e_addr = pend.pop_front();
            e_data = fcol;
        end
        if (e_en) mref[e_addr] = e_data;
        e_err  = (ph == 0) && fill_start && !ok;
        streak = (ph == 1 && m_ack) ? streak + 1 : 0;
        case (ph)
            0: if (fill_start && ok) begin
                pend.delete();
                for (int y = int'(fill_y0); y <= int'(fill_y1); y++)
                    for (int x = int'(fill_x0); x <= int'(fill_x1); x++)
                        pend.push_back(8'(y * 16 + x));
                fcol = fill_color;
                ph = 1;
            end
            1: if (m_slot && pend.size() == 0) ph = 2;
            default: ph = 0;
        endcase
        last_ack = m_ack;
        cyc++;
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic start_fill(input logic [3:0] x0, input logic [3:0] y0,
                              input logic [3:0] x1, input logic [3:0] y1,
                              input logic [7:0] col, output int t0);
        fill_x0 = x0;
        fill_y0 = y0;
        fill_x1 = x1;
        fill_y1 = y1;
        fill_color = col;
        fill_start = 1;
        t0 = cyc;
        step();
        fill_start = 0;
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while (ph != 0 && n < maxc) begin
            step();
            n++;
        end
        nchk++;
        if (ph != 0) begin
            nerr++;
            $display("FAIL timeout: fill still active after %0d cycles", maxc);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        RST_N = 1;
        host_wr_req = 1;
        host_wr_addr = 8'h5A;
        host_wr_data = 8'h77;
        fill_start = 1;
        fill_x0 = 0;
        fill_y0 = 0;
        fill_x1 = 3;
        fill_y1 = 3;
        fill_color = 8'hE0;
        repeat (2) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        nchk++;
        if ({host_wr_ack, mem_wr_en, mem_wr_addr, mem_wr_data,
             fill_busy, fill_done, fill_err} !== 21'd0) begin
            nerr++;
            $display("FAIL reset_state: ack=%b en=%b a=%h d=%h busy=%b done=%b err=%b want all 0",
                     host_wr_ack, mem_wr_en, mem_wr_addr, mem_wr_data,
                     fill_busy, fill_done, fill_err);
        end
        host_wr_req = 0;
        fill_start = 0;
        @(posedge VGA_CLK);
        #1;
        RST_N = 0;
        model_reset();
        step();
    endtask

    task automatic test_idle_host();
        host_wr_req = 1;
        host_wr_addr = 8'hA5;
        host_wr_data = 8'h03;
        #1;
        nchk++;
        if (host_wr_ack !== 1'b1) begin
            nerr++;
            $display("FAIL idle_ack got=%b want=1", host_wr_ack);
        end
        step();
        host_wr_req = 0;
        nchk++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 8'hA5, 8'h03}) begin
            nerr++;
            $display("FAIL idle_write got en=%b a=%h d=%h want 1 a5 03",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        step();
    endtask

    task automatic test_full_fill();
        int t0;
        int bad;
        clear_obs();
        start_fill(0, 0, 15, 15, 8'hE0, t0);
        run_until_idle(400);
        bad = 0;
        foreach (obs_a[i])
            if (obs_a[i] !== 8'(i) || obs_d[i] !== 8'hE0) bad++;
        nchk++;
        if (obs_a.size() != 256 || bad != 0) begin
            nerr++;
            $display("FAIL full_seq got %0d writes %0d bad want 256 writes 0 bad",
                     obs_a.size(), bad);
        end
        nchk++;
        if (obs_t.size() < 1 || obs_t[0] != t0 + 2 ||
            obs_t[obs_t.size()-1] != t0 + 257) begin
            nerr++;
            $display("FAIL full_timing got first=%0d want %0d",
                     obs_t.size() > 0 ? obs_t[0] : -1, t0 + 2);
        end
        nchk++;
        if (done_cnt != 1) begin
            nerr++;
            $display("FAIL full_done got %0d pulses want 1", done_cnt);
        end
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem_obs[i] !== 8'hE0) bad++;
        nchk++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL full_buffer got %0d non-E0 entries want 0", bad);
        end
    endtask

    task automatic test_sub_rect();
        int t0;
        logic [7:0] exp_a[6];
        int bad;
        exp_a = '{8'h32, 8'h33, 8'h34, 8'h42, 8'h43, 8'h44};
        clear_obs();
        start_fill(2, 3, 4, 4, 8'h1C, t0);
        run_until_idle(50);
        bad = 0;
        if (obs_a.size() == 6)
            foreach (exp_a[i])
                if (obs_a[i] !== exp_a[i] || obs_d[i] !== 8'h1C) bad++;
        nchk++;
        if (obs_a.size() != 6 || bad != 0) begin
            nerr++;
            $display("FAIL sub_seq got %0d writes %0d bad want 6 writes 0 bad",
                     obs_a.size(), bad);
        end
        nchk++;
        if (done_cnt != 1 || obs_t.size() != 6 || done_t != t0 + 7) begin
            nerr++;
            $display("FAIL sub_done got cnt=%0d at %0d want 1 at %0d",
                     done_cnt, done_t, t0 + 7);
        end
    endtask

    task automatic test_reject();
        int t0;
        clear_obs();
        start_fill(5, 0, 4, 0, 8'hFC, t0);
        nchk++;
        if (fill_err !== 1'b1 || fill_busy !== 1'b0) begin
            nerr++;
            $display("FAIL reject got err=%b busy=%b want 1 0", fill_err, fill_busy);
        end
        repeat (4) step();
        nchk++;
        if (obs_a.size() != 0 || done_cnt != 0) begin
            nerr++;
            $display("FAIL reject_quiet got %0d writes %0d done want 0 0",
                     obs_a.size(), done_cnt);
        end
    endtask

    task automatic test_starve();
        int t0;
        int hits;
        logic [5:0] seq;
        clear_obs();
        host_wr_req = 1;
        host_wr_data = 8'hAA;
        host_wr_addr = 8'($urandom);
        start_fill(1, 1, 1, 1, 8'h03, t0);
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            host_wr_addr = 8'($urandom);
            #1;
            seq = {seq[4:0], host_wr_ack};
            step();
        end
        nchk++;
        if (seq !== 6'b111101) begin
            nerr++;
            $display("FAIL starve_acks got=%b want=111101", seq);
        end
        host_wr_req = 0;
        run_until_idle(20);
        hits = 0;
        foreach (obs_a[i])
            if (obs_a[i] == 8'h11 && obs_d[i] == 8'h03) hits++;
        nchk++;
        if (hits != 1 || done_cnt != 1) begin
            nerr++;
            $display("FAIL starve_fill got %0d fill writes %0d done want 1 1",
                     hits, done_cnt);
        end
    endtask

    task automatic test_busy_restart();
        int t0;
        int bad;
        clear_obs();
        start_fill(0, 0, 3, 1, 8'hE0, t0);
        step();
        fill_x0 = 5;
        fill_y0 = 5;
        fill_x1 = 6;
        fill_y1 = 6;
        fill_color = 8'hFC;
        fill_start = 1;
        step();
        fill_start = 0;
        run_until_idle(40);
        bad = 0;
        if (obs_a.size() == 8)
            foreach (obs_a[i])
                if (obs_a[i] !== 8'((i / 4) * 16 + (i % 4)) || obs_d[i] !== 8'hE0)
                    bad++;
        nchk++;
        if (obs_a.size() != 8 || bad != 0 || done_cnt != 1) begin
            nerr++;
            $display("FAIL busy_restart got %0d writes %0d bad %0d done want 8 0 1",
                     obs_a.size(), bad, done_cnt);
        end
    endtask

    task automatic test_random();
        int t0;
        int bad;
        logic [3:0] x0;
        logic [3:0] y0;
        logic [3:0] x1;
        logic [3:0] y1;
        for (int it = 0; it < 8; it++) begin
            clear_obs();
            x0 = 4'($urandom_range(0, 15));
            y0 = 4'($urandom_range(0, 15));
            x1 = 4'($urandom_range(int'(x0), 15));
            y1 = 4'($urandom_range(int'(y0), 15));
            start_fill(x0, y0, x1, y1, 8'($urandom), t0);
            for (int n = 0; n < 1500 && ph != 0; n++) begin
                if (!host_wr_req || last_ack) begin
                    host_wr_req = ($urandom_range(0, 3) != 0);
                    host_wr_addr = 8'($urandom);
                    host_wr_data = 8'($urandom);
                end
                fill_start = ($urandom_range(0, 7) == 0);
                fill_x0 = 4'($urandom);
                fill_x1 = 4'($urandom);
                step();
                fill_start = 0;
            end
            host_wr_req = 0;
            run_until_idle(10);
            nchk++;
            if (done_cnt != 1) begin
                nerr++;
                $display("FAIL rand_done it=%0d got %0d want 1", it, done_cnt);
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem_obs[i] !== mref[i]) bad++;
        nchk++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL rand_buffer got %0d differing entries want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int n;
        clear_obs();
        start_fill(0, 0, 15, 15, 8'hE0, t0);
        n = 0;
        while (obs_a.size() < 100 && n < 300) begin
            step();
            n++;
        end
        nchk++;
        if (obs_a.size() != 100) begin
            nerr++;
            $display("FAIL mid_count got %0d writes want 100", obs_a.size());
        end
        RST_N = 1;
        #1;
        nchk++;
        if ({host_wr_ack, mem_wr_en, mem_wr_addr, mem_wr_data,
             fill_busy, fill_done, fill_err} !== 21'd0) begin
            nerr++;
            $display("FAIL mid_reset got en=%b a=%h d=%h busy=%b want all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, fill_busy);
        end
        @(posedge VGA_CLK);
        #1;
        nchk++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, fill_busy, fill_done} !== 19'd0) begin
            nerr++;
            $display("FAIL mid_reset_edge got en=%b a=%h d=%h busy=%b want all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, fill_busy);
        end
        RST_N = 0;
        model_reset();
        clear_obs();
        repeat (30) step();
        nchk++;
        if (obs_a.size() != 0 || done_cnt != 0) begin
            nerr++;
            $display("FAIL mid_after got %0d writes %0d done want 0 0",
                     obs_a.size(), done_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mref[i] = 8'hxx;
            mem_obs[i] = 8'hxx;
        end
        model_reset();
        clear_obs();
        test_reset();
        test_idle_host();
        test_full_fill();
        test_sub_rect();
        test_reject();
        test_starve();
        test_busy_restart();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
